// File: rtl/bit_wise_serial_shifter_if.sv
// Request/result handshake bundle for the bit-wise serial shifter.
interface bit_wise_serial_shifter_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned S = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [S-1:0] shamt;
    logic         dir;
    logic         arith;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;

    // Requester / result consumer side
    modport master (
        output in_valid, a, shamt, dir, arith, out_ready,
        input  in_ready, out_valid, c
    );

    // Shifter side
    modport slave (
        input  in_valid, a, shamt, dir, arith, out_ready,
        output in_ready, out_valid, c
    );
endinterface

// File: rtl/bit_wise_serial_shifter.sv
// Multi-cycle shifter: one bit position per clock, valid/ready on both sides.
module bit_wise_serial_shifter #(
    parameter int unsigned N = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    bit_wise_serial_shifter_if.slave  bus,
    output logic                      busy
);
    localparam int unsigned S = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e       state_q,     state_d;
    logic [N-1:0] data_q,      data_d;
    logic [S-1:0] count_q,     count_d;
    logic         dir_q,       dir_d;
    logic         arith_q,     arith_d;
    logic         in_ready_q,  in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q,      busy_d;

    // Next-state, datapath step and registered-output decode
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        dir_d   = dir_q;
        arith_d = arith_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.a;
                    count_d = bus.shamt;
                    dir_d   = bus.dir;
                    arith_d = bus.arith;
                    state_d = (bus.shamt == S'(0)) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Arith only matters for right shifts: fill with MSB, else zero
                if (!dir_q) begin
                    data_d = {data_q[N-2:0], 1'b0};
                end else begin
                    data_d = {arith_q & data_q[N-1], data_q[N-1:1]};
                end
                count_d = count_q - S'(1);
                if (count_q == S'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags decoded from the upcoming state so they leave a flop
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            data_q      <= '0;
            count_q     <= '0;
            dir_q       <= 1'b0;
            arith_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            arith_q     <= arith_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = data_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_bit_wise_serial_shifter.sv
// Self-checking bench for bit_wise_serial_shifter (N=8).
module tb_bit_wise_serial_shifter;

    logic clk;
    logic rstn;
    logic busy;

    bit_wise_serial_shifter_if #(.N(8)) bus ();

    bit_wise_serial_shifter #(.N(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Comparison helper: counts every check, reports each failure on one line
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference shift from plain operators
    function automatic logic [7:0] ref_shift(input logic [7:0] v, input int sh,
                                             input logic d, input logic ar);
        logic [7:0] r;
        if (!d)      r = v << sh;
        else if (ar) r = 8'($signed(v) >>> sh);
        else         r = v >> sh;
        return r;
    endfunction

    // Transaction-level model: result and the edge at which it becomes visible
    int         cyc = 0;
    bit         m_known = 0;
    bit         m_busy  = 0;
    bit         m_valid = 0;
    logic [7:0] m_res   = '0;
    int         m_valid_at = 0;
    int         m_acc  = 0;
    int         m_done = 0;
    int         dut_done = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && rstn === 1'b1)
            dut_done++;
        if (rstn === 1'b0) begin
            m_known = 1;
            m_busy  = 0;
            m_valid = 0;
        end else if (m_known) begin
            if (!m_busy) begin
                if (bus.in_valid) begin
                    m_busy     = 1;
                    m_res      = ref_shift(bus.a, int'(bus.shamt), bus.dir, bus.arith);
                    m_valid_at = cyc + int'(bus.shamt);
                    m_valid    = (cyc == m_valid_at);
                    m_acc++;
                end
            end else if (m_valid) begin
                if (bus.out_ready) begin
                    m_busy  = 0;
                    m_valid = 0;
                    m_done++;
                end
            end else if (cyc >= m_valid_at) begin
                m_valid = 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (m_known) begin
            chk("mdl_in_ready",  32'(bus.in_ready),  32'(!m_busy));
            chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("mdl_busy",      32'(busy),          32'(m_busy));
            if (m_valid) chk("mdl_c", 32'(bus.c), 32'(m_res));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int last_acc = 0;

    // Present a request, hold until accepted, then scramble inputs
    task automatic send(input logic [7:0] av, input logic [2:0] sv,
                        input logic d, input logic ar);
        int t;
        bus.a = av; bus.shamt = sv; bus.dir = d; bus.arith = ar;
        bus.in_valid = 1'b1;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        if (t >= 40) chk("accept_timeout", 32'(t), 32'(0));
        last_acc = cyc;
        tick();
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom);
        bus.shamt = 3'($urandom_range(0, 7));
        bus.dir = 1'($urandom_range(0, 1));
        bus.arith = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(output int lat);
        int t;
        t = 0;
        while (bus.out_valid !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        if (t >= 40) chk("valid_timeout", 32'(t), 32'(0));
        lat = cyc - last_acc;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run_req(input string name, input logic [7:0] av, input logic [2:0] sv,
                           input logic d, input logic ar,
                           input logic [7:0] exp_c, input int exp_lat);
        int lat;
        send(av, sv, d, ar);
        wait_valid(lat);
        chk({name, "_c"},    32'(bus.c), 32'(exp_c));
        chk({name, "_lat"},  32'(lat),   32'(exp_lat));
        chk({name, "_busy"}, 32'(busy),  32'(1));
        handshake();
        chk({name, "_idle"}, 32'(busy),  32'(0));
    endtask

    initial begin
        int lat;
        int sent;
        int guard;
        int start_done;
        int start_acc;
        logic rdy;

        rstn = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.shamt = '0;
        bus.dir = 1'b0; bus.arith = 1'b0; bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_c",         32'(bus.c),         32'(0));
        chk("rst_busy",      32'(busy),          32'(0));
        rstn = 1'b1;
        tick();

        // Directed vectors with hand-derived results
        run_req("left3",   8'hB5, 3'd3, 1'b0, 1'b0, 8'hA8, 4);
        run_req("arith3",  8'hB5, 3'd3, 1'b1, 1'b1, 8'hF6, 4);
        run_req("logic3",  8'hB5, 3'd3, 1'b1, 1'b0, 8'h16, 4);
        run_req("leftar3", 8'hB5, 3'd3, 1'b0, 1'b1, 8'hA8, 4);
        run_req("zero",    8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, 1);
        run_req("arith7",  8'h80, 3'd7, 1'b1, 1'b1, 8'hFF, 8);
        run_req("logic7",  8'h80, 3'd7, 1'b1, 1'b0, 8'h01, 8);
        run_req("left7",   8'h01, 3'd7, 1'b0, 1'b0, 8'h80, 8);

        // Backpressure: result held through a long stall, new request waits
        send(8'hB5, 3'd3, 1'b0, 1'b0);
        wait_valid(lat);
        bus.a = 8'h5A; bus.shamt = 3'd0; bus.dir = 1'b0; bus.arith = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_c",        32'(bus.c),         32'(8'hA8));
            chk("stall_valid",    32'(bus.out_valid), 32'(1));
            chk("stall_in_ready", 32'(bus.in_ready),  32'(0));
            tick();
        end
        handshake();
        chk("post_hs_in_ready",  32'(bus.in_ready),  32'(1));
        chk("post_hs_out_valid", 32'(bus.out_valid), 32'(0));
        tick();
        bus.in_valid = 1'b0;
        chk("next_valid", 32'(bus.out_valid), 32'(1));
        chk("next_c",     32'(bus.c),         32'(8'h5A));
        handshake();

        // Reset while shifting with two steps left
        send(8'h3C, 3'd5, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("pre_rst_busy",  32'(busy),          32'(1));
        chk("pre_rst_valid", 32'(bus.out_valid), 32'(0));
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'(0));
        chk("abort_c",         32'(bus.c),         32'(0));
        chk("abort_in_ready",  32'(bus.in_ready),  32'(1));
        chk("abort_busy",      32'(busy),          32'(0));
        run_req("after_rst", 8'hB5, 3'd3, 1'b1, 1'b1, 8'hF6, 4);

        // Back-to-back random stream with random consumer backpressure
        start_done = dut_done;
        start_acc  = m_acc;
        sent  = 0;
        guard = 0;
        bus.a = 8'($urandom); bus.shamt = 3'($urandom_range(0, 7));
        bus.dir = 1'($urandom_range(0, 1)); bus.arith = 1'($urandom_range(0, 1));
        bus.in_valid = 1'b1;
        while ((sent < 1000 || dut_done - start_done < 1000) && guard < 60000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            rdy = bus.in_ready;
            tick();
            guard++;
            if (bus.in_valid && rdy === 1'b1) begin
                sent++;
                if (sent < 1000) begin
                    bus.a = 8'($urandom); bus.shamt = 3'($urandom_range(0, 7));
                    bus.dir = 1'($urandom_range(0, 1)); bus.arith = 1'($urandom_range(0, 1));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.out_ready = 1'b0;
        chk("stream_timeout",  32'(guard < 60000),          32'(1));
        chk("stream_sent",     32'(sent),                   32'(1000));
        chk("stream_done",     32'(dut_done - start_done),  32'(1000));
        chk("stream_model_acc", 32'(m_acc - start_acc),     32'(1000));
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
